// File: rtl/seq_disp_pkg.sv
// Shared definitions for the BCD display block.
//   state_e       : conversion FSM states (IDLE / SHIFT / DONE)
//   SEG_BLANK     : all segments off, gfedcba order, before polarity
//   SEG_TABLE     : gfedcba codes for digits 0..9, 1 = segment lit
//   dabble_adjust : add 3 to every BCD nibble that is >= 5 (double-dabble step)
package seq_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Nibbles never exceed 9 going in, so the 4-bit add of 3 cannot overflow.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD nibble to 7-segment decoder.
//   nibble_i : BCD digit; values above 9 decode to blank
//   blank_i  : force the digit dark
//   seg_o    : {g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW = 1
module bcd_seg_decoder
  import seq_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] lit;

  always_comb begin
    lit = SEG_BLANK;
    if (!blank_i && (nibble_i <= 4'd9)) lit = SEG_TABLE[nibble_i];
    // Polarity goes last so a blank digit is dark on either panel type.
    seg_o = SEG_ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/seq_bcd_display.sv
// Accepts an 8-bit value over valid/ready, converts it to three BCD digits with a
// sequential double-dabble engine (one shift per clock), and scans the last result
// onto a time-multiplexed 3-digit 7-segment display.
//   clk, reset : clock; synchronous active-high reset
//   in_valid   : in_data holds a sample
//   in_ready   : high only while IDLE
//   in_data    : unsigned value 0..255
//   bcd_out    : {hundreds,tens,ones} of the last completed conversion
//   bcd_valid  : one-cycle pulse when bcd_out updates
//   seg        : {g,f,e,d,c,b,a} of the currently selected digit
//   digit_en   : one-hot digit select, bit0 = ones, bit2 = hundreds
module seq_bcd_display
  import seq_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [2:0]  digit_en
);

  localparam int unsigned       CW           = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]     REFRESH_LAST = CW'(REFRESH_DIV - 1);

  state_e      state_q, state_d;
  logic [19:0] scratch_q, scratch_d;   // {hundreds, tens, ones, binary}
  logic [19:0] adjusted;
  logic [2:0]  shift_cnt_q, shift_cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        bcd_valid_q;
  logic [CW-1:0] refresh_q;
  logic [1:0]  dig_idx_q;
  logic [3:0]  sel_nibble;
  logic        sel_blank;

  // Conversion FSM and datapath registers.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; reset is synchronous, so it only appears inside the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      scratch_q   <= '0;
      shift_cnt_q <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scratch_q   <= scratch_d;
      shift_cnt_q <= shift_cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= (state_q == DONE);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    scratch_d   = scratch_q;
    shift_cnt_d = shift_cnt_q;
    bcd_d       = bcd_q;
    adjusted    = {dabble_adjust(scratch_q[19:8]), scratch_q[7:0]};
    unique case (state_q)
      IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          scratch_d   = {12'b0, in_data};
          shift_cnt_d = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d   = {adjusted[18:0], 1'b0};
        shift_cnt_d = shift_cnt_q + 3'd1;
        if (shift_cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q[19:8];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan: free-running, never restarted by a new conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      dig_idx_q <= '0;
    end else if (refresh_q == REFRESH_LAST) begin
      refresh_q <= '0;
      dig_idx_q <= (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Tens is only a leading zero when hundreds is also zero.
  always_comb begin
    sel_nibble = bcd_q[3:0];
    sel_blank  = 1'b0;
    unique case (dig_idx_q)
      2'd1: begin
        sel_nibble = bcd_q[7:4];
        sel_blank  = BLANK_LEADING && (bcd_q[11:4] == 8'd0);
      end
      2'd2: begin
        sel_nibble = bcd_q[11:8];
        sel_blank  = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  bcd_seg_decoder #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .nibble_i (sel_nibble),
    .blank_i  (sel_blank),
    .seg_o    (seg)
  );

  assign in_ready  = (state_q == IDLE);
  assign bcd_out   = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign digit_en  = 3'b001 << dig_idx_q;

endmodule

// File: tb/tb_seq_bcd_display.sv
module tb_seq_bcd_display;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready_a, bcd_valid_a, in_ready_b, bcd_valid_b;
  logic [11:0] bcd_out_a, bcd_out_b;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  digit_en_a, digit_en_b;

  int errors = 0;
  int checks = 0;
  int scan_n;

  // Active-high panel and active-low panel fed from the same stimulus.
  seq_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .bcd_out(bcd_out_a), .bcd_valid(bcd_valid_a),
    .seg(seg_a), .digit_en(digit_en_a)
  );

  seq_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .bcd_out(bcd_out_b), .bcd_valid(bcd_valid_b),
    .seg(seg_b), .digit_en(digit_en_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference scan position: number of non-reset edges since reset.
  always @(posedge clk) begin
    if (reset) scan_n <= 0;
    else       scan_n <= scan_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  value;
    logic [11:0] bcd;
    logic [6:0]  seg1;
    logic [6:0]  seg10;
    logic [6:0]  seg100;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present one value, then follow it to its bcd_valid pulse.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd);
    int lat;
    logic busy_ok;
    in_data  = v;
    in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    check("accept_ready_low", in_ready_a, 1'b0);
    lat = 0;
    busy_ok = 1'b1;
    while (!bcd_valid_a && lat < 20) begin
      tick();
      lat++;
      if (!bcd_valid_a && in_ready_a) busy_ok = 1'b0;
    end
    check("busy_ready_low", busy_ok, 1'b1);
    check("latency", lat, 9);
    check("bcd_out", bcd_out_a, exp_bcd);
    check("bcd_out_b", bcd_out_b, exp_bcd);
    check("ready_after_done", in_ready_a, 1'b1);
    tick();
    check("valid_one_cycle", bcd_valid_a, 1'b0);
  endtask

  // Watch three full scan periods and compare each digit against the model.
  task automatic check_scan(input logic [6:0] s1, input logic [6:0] s10, input logic [6:0] s100);
    int idx;
    logic [6:0] exp_a, exp_b;
    logic [2:0] exp_en;
    for (int c = 0; c < 12; c++) begin
      tick();
      idx    = (scan_n / 4) % 3;
      exp_en = 3'b001 << idx;
      exp_a  = (idx == 0) ? s1 : (idx == 1) ? s10 : s100;
      exp_b  = ~exp_a;
      check("digit_en", digit_en_a, exp_en);
      check("seg_high", seg_a, exp_a);
      check("seg_low", seg_b, exp_b);
    end
  endtask

  initial begin
    int pulses, first_t, second_t;

    vecs[0] = '{8'd255, 12'h255, 7'h6D, 7'h6D, 7'h5B};
    vecs[1] = '{8'd7,   12'h007, 7'h07, 7'h00, 7'h00};
    vecs[2] = '{8'd100, 12'h100, 7'h3F, 7'h3F, 7'h06};
    vecs[3] = '{8'd0,   12'h000, 7'h3F, 7'h00, 7'h00};
    vecs[4] = '{8'd9,   12'h009, 7'h6F, 7'h00, 7'h00};
    vecs[5] = '{8'd10,  12'h010, 7'h3F, 7'h06, 7'h00};
    vecs[6] = '{8'd99,  12'h099, 7'h6F, 7'h6F, 7'h00};
    vecs[7] = '{8'd128, 12'h128, 7'h7F, 7'h5B, 7'h06};
    vecs[8] = '{8'd205, 12'h205, 7'h6D, 7'h3F, 7'h5B};
    vecs[9] = '{8'd38,  12'h038, 7'h7F, 7'h4F, 7'h00};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    tick();
    tick();
    check("rst_ready", in_ready_a, 1'b1);
    check("rst_bcd", bcd_out_a, 12'h000);
    check("rst_valid", bcd_valid_a, 1'b0);
    check("rst_digit_en", digit_en_a, 3'b001);
    check("rst_seg_high", seg_a, 7'h3F);
    check("rst_seg_low", seg_b, 7'h40);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].value, vecs[i].bcd);
      check_scan(vecs[i].seg1, vecs[i].seg10, vecs[i].seg100);
    end

    // Reset lands on E4 of a conversion of 200.
    in_data  = 8'd200;
    in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    check("abort_accept", in_ready_a, 1'b0);
    tick(); tick(); tick();                   // E1..E3
    reset = 1'b1;
    tick();                                   // E4 with reset
    check("abort_bcd", bcd_out_a, 12'h000);
    check("abort_ready", in_ready_a, 1'b1);
    check("abort_valid", bcd_valid_a, 1'b0);
    check("abort_digit_en", digit_en_a, 3'b001);
    check("abort_seg", seg_a, 7'h3F);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bcd_valid_a) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_ready_end", in_ready_a, 1'b1);
    check("abort_bcd_end", bcd_out_a, 12'h000);

    // Reset and in_valid together: nothing captured.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_valid_ready", in_ready_a, 1'b1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bcd_valid_a || !in_ready_a) pulses++;
    end
    check("rst_valid_no_capture", pulses, 0);
    check("rst_valid_bcd", bcd_out_a, 12'h000);

    // Back-to-back with in_valid held high: 1 then 2.
    in_data  = 8'd1;
    in_valid = 1'b1;
    pulses   = 0;
    first_t  = -1;
    second_t = -1;
    for (int c = 0; c < 40 && pulses < 2; c++) begin
      tick();
      if (c == 0) begin
        check("b2b_accept1", in_ready_a, 1'b0);
        in_data = 8'd2;
      end
      if (bcd_valid_a) begin
        pulses++;
        if (pulses == 1) begin
          first_t = c;
          check("b2b_bcd1", bcd_out_a, 12'h001);
        end else begin
          second_t = c;
          check("b2b_bcd2", bcd_out_a, 12'h002);
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bcd_valid_a) pulses++;
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_first_latency", first_t, 9);
    check("b2b_spacing", second_t - first_t, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
